// File: rtl/rle_write_arbiter_pkg.sv
// Shared types and helpers for the run-length decode FIFO write arbiter.
// The default widths match the decode FIFO entry: an 8-bit byte and a 4-bit run count.
package rle_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam int DW_DEFAULT = 8;
    localparam int CW_DEFAULT = 4;
    localparam int MAX_REQ    = 8;

    // OR-reduction of set-bit positions; exact for one-hot input, 0 for all-zero
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rle_write_arbiter_rr_pick.sv
// Combinational round-robin selector. It returns the first set request after
// rr_ptr, scanning upward with wrap, as both a one-hot vector and an index.
module rle_write_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    always_comb begin
        int p;
        p       = 0;
        win_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            p = (int'(rr_ptr) + k) % N;
            if (!any && req[p]) begin
                any     = 1'b1;
                win_idx = IW'(p);
            end
        end
        win = any ? (N'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/rle_write_arbiter.sv
// Round-robin arbiter for the run-length decode FIFO write port. It grants one producer
// a bounded burst of (data, count) pairs and drops zero-count pairs without writing them.
module rle_write_arbiter
    import rle_write_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DW_DEFAULT,
    parameter int CW    = CW_DEFAULT,
    parameter int BURST = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    last,
    input  logic [N_REQ*DW-1:0] din,
    input  logic [N_REQ*CW-1:0] cin,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    grant,
    input  logic                fifo_full,
    output logic                wr_en,
    output logic [DW-1:0]       data_din,
    output logic [CW-1:0]       data_cin,
    output logic [7:0]          drop_cnt,
    output logic                busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(BURST + 1);

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [BW-1:0]      beat_reg, beat_next;
    logic [7:0]         drop_cnt_reg;

    logic [IW-1:0]      owner;
    logic               owner_req;
    logic               owner_last;
    logic               acc;
    logic               drop;
    logic               beat_final;

    logic [N_REQ-1:0]   pick_win;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    rle_write_arbiter_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // With grant all-zero the owner index is 0, so the data mux idles on lane 0
    assign owner      = IW'(onehot_to_idx(MAX_REQ'(grant_reg)));
    assign owner_req  = req[owner];
    assign owner_last = last[owner];
    assign data_din   = din[owner*DW +: DW];
    assign data_cin   = cin[owner*CW +: CW];

    assign busy       = (state_reg == ST_OWN);
    assign acc        = busy & owner_req & ~fifo_full;
    assign wr_en      = acc & (data_cin != '0);
    assign drop       = acc & (data_cin == '0);
    assign beat_final = (beat_reg == BW'(BURST - 1));

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack[gi] = acc & grant_reg[gi];
        end
    endgenerate

    assign grant    = grant_reg;
    assign drop_cnt = drop_cnt_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= IW'(N_REQ - 1);
            beat_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            beat_reg   <= beat_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        beat_next   = beat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next  = ST_OWN;
                    grant_next  = pick_win;
                    rr_ptr_next = pick_idx;
                    beat_next   = '0;
                end
            end
            ST_OWN: begin
                if (acc) begin
                    beat_next = beat_reg + 1'b1;
                end
                // A stalled owner (fifo_full) never releases, even if last is set
                if ((acc & (owner_last | beat_final)) | ~owner_req) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

endmodule

// File: tb/tb_rle_write_arbiter.sv
// Directed bench for rle_write_arbiter (N_REQ=4, BURST=4). Inputs change 1 time unit
// after the rising edge, and outputs are sampled on the falling edge.
module tb_rle_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] din;
    logic [15:0] cin;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        fifo_full;
    logic        wr_en;
    logic [7:0]  data_din;
    logic [3:0]  data_cin;
    logic [7:0]  drop_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    rle_write_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .last      (last),
        .din       (din),
        .cin       (cin),
        .ack       (ack),
        .grant     (grant),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .data_din  (data_din),
        .data_cin  (data_cin),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    task automatic test_reset();
        RST = 1'b0; req = '0; last = '0; din = '0; cin = '0; fifo_full = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want %b", grant, 4'b0000); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want %b", ack, 4'b0000); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        @(posedge CLK); #1;
        RST = 1'b1;
    endtask

    task automatic test_single();
        @(posedge CLK); #1;
        req = 4'b0001; din[7:0] = 8'hA5; cin[3:0] = 4'd3; last = 4'b0001;
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_latency_grant: got %b want %b", grant, 4'b0000); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ack: got %b want %b", ack, 4'b0000); end
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want %b", grant, 4'b0001); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want %b", ack, 4'b0001); end
        n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en: got %b want 1", wr_en); end
        n_checks++; if (data_din !== 8'hA5) begin n_fail++; $display("FAIL single_data_din: got %h want a5", data_din); end
        n_checks++; if (data_cin !== 4'd3) begin n_fail++; $display("FAIL single_data_cin: got %0d want 3", data_cin); end
        @(posedge CLK); #1;
        req = '0; last = '0;
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_release_grant: got %b want %b", grant, 4'b0000); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release_busy: got %b want 0", busy); end
    endtask

    // The previous winner was producer 0, so the rotation starts at producer 1
    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        @(posedge CLK); #1;
        req = 4'b1111; last = 4'b1111; cin = 16'h1111; din = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_bubble_%0d: got %b want %b", k, grant, 4'b0000); end
            n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rr_bubble_ack_%0d: got %b want %b", k, ack, 4'b0000); end
            @(negedge CLK);
            n_checks++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", k, grant, exp_g[k]); end
            n_checks++; if (ack !== exp_g[k]) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", k, ack, exp_g[k]); end
            n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_wr_en_%0d: got %b want 1", k, wr_en); end
        end
        @(posedge CLK); #1;
        req = '0; last = '0;
    endtask

    task automatic test_burst();
        logic [3:0] exp_g [11] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                   4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        logic [3:0] a;
        int p1_sent;
        p1_sent = 0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        req = 4'b0110; last = 4'b0100;
        din[15:8] = 8'h10; din[23:16] = 8'h20; cin[7:4] = 4'd1; cin[11:8] = 4'd2;
        for (int k = 0; k < 11; k++) begin
            @(negedge CLK);
            n_checks++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL burst_grant_%0d: got %b want %b", k, grant, exp_g[k]); end
            n_checks++; if (ack !== exp_g[k]) begin n_fail++; $display("FAIL burst_ack_%0d: got %b want %b", k, ack, exp_g[k]); end
            if (k == 3) begin
                n_checks++; if (data_din !== 8'(8'h10 + p1_sent)) begin n_fail++; $display("FAIL burst_data_%0d: got %h want %h", k, data_din, 8'(8'h10 + p1_sent)); end
            end
            a = ack;
            @(posedge CLK); #1;
            if (a[1]) begin
                p1_sent++;
                din[15:8] = 8'(8'h10 + p1_sent);
                last[1] = (p1_sent == 5);
                if (p1_sent == 6) req[1] = 1'b0;
            end
            if (a[2]) begin
                req[2] = 1'b0; last[2] = 1'b0;
            end
        end
        n_checks++; if (p1_sent != 6) begin n_fail++; $display("FAIL burst_p1_pairs: got %0d want 6", p1_sent); end
        req = '0; last = '0;
    endtask

    // After the stall, a full burst of 4 acks shows that the stalled cycles did not advance beat
    task automatic test_fifo_full();
        int n_ack;
        n_ack = 0;
        @(posedge CLK); #1;
        req = 4'b0001; last = 4'b0000; din[7:0] = 8'h3C; cin[3:0] = 4'd5; fifo_full = 1'b1;
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL full_idle_grant: got %b want %b", grant, 4'b0000); end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL full_grant_%0d: got %b want %b", k, grant, 4'b0001); end
            n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL full_ack_%0d: got %b want %b", k, ack, 4'b0000); end
            n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL full_wr_en_%0d: got %b want 0", k, wr_en); end
        end
        @(posedge CLK); #1;
        fifo_full = 1'b0;
        @(negedge CLK);
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL full_resume_ack: got %b want %b", ack, 4'b0001); end
        n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL full_resume_wr_en: got %b want 1", wr_en); end
        n_checks++; if (data_din !== 8'h3C) begin n_fail++; $display("FAIL full_resume_din: got %h want 3c", data_din); end
        n_checks++; if (data_cin !== 4'd5) begin n_fail++; $display("FAIL full_resume_cin: got %0d want 5", data_cin); end
        for (int c = 0; c < 10; c++) begin
            if (ack[0]) n_ack++;
            if (grant == 4'b0000) break;
            @(negedge CLK);
        end
        req = '0;
        n_checks++; if (n_ack != 4) begin n_fail++; $display("FAIL full_burst_len: got %0d want 4", n_ack); end
    endtask

    task automatic test_drop();
        int n_ack;
        int n_wr;
        n_ack = 0; n_wr = 0;
        @(posedge CLK); #1;
        req = 4'b1000; last = 4'b0000; cin[15:12] = 4'd0; din[31:24] = 8'h77;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL drop_ack_%0d: got %b want %b", k, ack, 4'b1000); end
            n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL drop_wr_en_%0d: got %b want 0", k, wr_en); end
            n_checks++; if (drop_cnt !== 8'(k)) begin n_fail++; $display("FAIL drop_cnt_%0d: got %0d want %0d", k, drop_cnt, k); end
        end
        @(posedge CLK); #1;
        cin[15:12] = 4'd2; last[3] = 1'b1;
        @(negedge CLK);
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL drop_fourth_ack: got %b want %b", ack, 4'b1000); end
        n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL drop_fourth_wr_en: got %b want 1", wr_en); end
        n_checks++; if (data_cin !== 4'd2) begin n_fail++; $display("FAIL drop_fourth_cin: got %0d want 2", data_cin); end
        n_checks++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL drop_cnt_three: got %0d want 3", drop_cnt); end
        @(posedge CLK); #1;
        req = '0; last = '0; cin[15:12] = 4'd0;
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL drop_release_grant: got %b want %b", grant, 4'b0000); end
        @(posedge CLK); #1;
        req = 4'b1000;
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            if (ack[3]) n_ack++;
            if (wr_en) n_wr++;
            if (ack[3] && n_ack == 250) begin
                n_checks++; if (drop_cnt !== 8'd252) begin n_fail++; $display("FAIL drop_cnt_mid: got %0d want 252", drop_cnt); end
            end
            if (n_ack == 300) break;
        end
        @(posedge CLK); #1;
        req = '0;
        @(negedge CLK);
        n_checks++; if (n_ack != 300) begin n_fail++; $display("FAIL drop_pairs_sent: got %0d want 300", n_ack); end
        n_checks++; if (n_wr != 0) begin n_fail++; $display("FAIL drop_zero_writes: got %0d want 0", n_wr); end
        n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_cnt_saturate: got %0d want 255", drop_cnt); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid_burst();
        @(posedge CLK); #1;
        req = 4'b0001; last = 4'b0000; cin[3:0] = 4'd1; din[7:0] = 8'h5A;
        repeat (3) @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL mid_pre_ack: got %b want %b", ack, 4'b0001); end
        #2;
        RST = 1'b0;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_grant: got %b want %b", grant, 4'b0000); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ack: got %b want %b", ack, 4'b0000); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_en: got %b want 0", wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        @(posedge CLK); #1;
        RST = 1'b1;
        req = 4'b0110; last = 4'b0110; cin = 16'h0110;
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_after_idle: got %b want %b", grant, 4'b0000); end
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL mid_after_grant: got %b want %b", grant, 4'b0010); end
        @(posedge CLK); #1;
        req = '0; last = '0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_fifo_full();
        test_drop();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
